uart_rx_fifo: RTL and testbench

Receive buffer that sits directly downstream of the UART receiver. It captures each byte presented with the receiver's one-cycle data_ready strobe into a circular FIFO and serves the bytes to the host side through a read-enable interface. It reports empty and full status and a fill count, and keeps sticky overflow and underflow flags.

---
 rtl/uart_rx_fifo.sv | 115 +++++++++++
 tb/tb_uart_rx_fifo.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: captures data_ready strobes, serves bytes to the host.
// Define UART_RX_FIFO_IRQ_EN to build the registered fill-level / overflow interrupt on irq.
module uart_rx_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int IRQ_LEVEL = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enable,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              rd_en,
    input  logic              flush,
    input  logic              clr_flags,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic [AW:0]       count,
    output logic              overflow,
    output logic              underflow,
    output logic              irq
);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (DEPTH != (1 << AW)) ||
        (IRQ_LEVEL < 1) || (IRQ_LEVEL > DEPTH)) begin : g_bad_cfg
        $error("uart_rx_fifo: inconsistent DEPTH/AW/IRQ_LEVEL");
    end

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    logic rd_accept;
    logic wr_accept;
    logic ovf_set;
    logic udf_set;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // A full FIFO still takes a byte when the same cycle frees a slot.
    assign rd_accept = rd_en && !empty && !flush;
    assign wr_accept = in_valid && enable && (!full || (rd_en && !empty)) && !flush;
    assign ovf_set   = in_valid && enable && full && !rd_en && !flush;
    assign udf_set   = rd_en && empty && !flush;

    // NOTE: storage carries no reset; its contents are don't-care until written,
    // and leaving it out keeps the array mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // NOTE: every state register uses non-blocking assignment so all updates
    // see the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rd_valid <= rd_accept;
            if (rd_accept) begin
                rd_data <= mem[rd_ptr];
            end

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (wr_accept) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (rd_accept) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({wr_accept, rd_accept})
                    2'b10:   count <= count + (AW + 1)'(1);
                    2'b01:   count <= count - (AW + 1)'(1);
                    default: count <= count;
                endcase
            end

            // Set beats a coincident clear.
            overflow  <= ovf_set || (overflow  && !clr_flags);
            underflow <= udf_set || (underflow && !clr_flags);
        end
    end

`ifdef UART_RX_FIFO_IRQ_EN
    localparam logic [AW:0] IRQ_CNT = (AW + 1)'(IRQ_LEVEL);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            irq <= 1'b0;
        end else begin
            irq <= (count >= IRQ_CNT) || overflow;
        end
    end
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo; irq expectations follow UART_RX_FIFO_IRQ_EN.
module tb_uart_rx_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;

    logic              clk = 1'b0;
    logic              resetn;
    logic              enable;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              rd_en;
    logic              flush;
    logic              clr_flags;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic [AW:0]       count;
    logic              overflow;
    logic              underflow;
    logic              irq;

    int tests  = 0;
    int failed = 0;

`ifdef UART_RX_FIFO_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    uart_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW), .IRQ_LEVEL(8)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .enable    (enable),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .rd_en     (rd_en),
        .flush     (flush),
        .clr_flags (clr_flags),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // Advance one clock and sample 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        step();
        in_valid = 1'b0;
    endtask

    task automatic read_once();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        step();
        step();
        #2 resetn = 1'b1;
        step();
    endtask

    task automatic test_reset();
        enable = 1'b1; in_data = '0; in_valid = 1'b0; rd_en = 1'b0;
        flush = 1'b0; clr_flags = 1'b0; resetn = 1'b0;
        #3;
        tests++;
        if ({count, empty, full, rd_valid, overflow, underflow, irq, rd_data} !==
            {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            failed++;
            $display("FAIL reset_state: count=%0d empty=%b full=%b rd_valid=%b ovf=%b udf=%b irq=%b rd_data=%h, want 0 1 0 0 0 0 0 00",
                     count, empty, full, rd_valid, overflow, underflow, irq, rd_data);
        end
        apply_reset();
    endtask

    task automatic test_basic();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h55; exp_b[1] = 8'hA3; exp_b[2] = 8'h0F;
        for (int i = 0; i < 3; i++) write_byte(exp_b[i]);
        tests++;
        if (count !== 5'd3 || empty !== 1'b0) begin
            failed++;
            $display("FAIL basic_count: count=%0d empty=%b, want 3 0", count, empty);
        end
        for (int i = 0; i < 3; i++) begin
            read_once();
            tests++;
            if (rd_valid !== 1'b1 || rd_data !== exp_b[i]) begin
                failed++;
                $display("FAIL basic_read%0d: rd_valid=%b rd_data=%h, want 1 %h", i, rd_valid, rd_data, exp_b[i]);
            end
        end
        step();
        tests++;
        if (empty !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 8'h0F) begin
            failed++;
            $display("FAIL basic_idle: empty=%b rd_valid=%b rd_data=%h, want 1 0 0f", empty, rd_valid, rd_data);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) write_byte(8'(i));
        tests++;
        if (full !== 1'b1 || count !== 5'd16) begin
            failed++;
            $display("FAIL ovf_full: full=%b count=%0d, want 1 16", full, count);
        end
        write_byte(8'hFF);
        tests++;
        if (overflow !== 1'b1 || count !== 5'd16) begin
            failed++;
            $display("FAIL ovf_drop: overflow=%b count=%0d, want 1 16", overflow, count);
        end
        for (int i = 0; i < 16; i++) begin
            read_once();
            tests++;
            if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
                failed++;
                $display("FAIL ovf_drain%0d: rd_valid=%b rd_data=%h, want 1 %h", i, rd_valid, rd_data, 8'(i));
            end
        end
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        tests++;
        if (overflow !== 1'b0 || empty !== 1'b1) begin
            failed++;
            $display("FAIL ovf_clear: overflow=%b empty=%b, want 0 1", overflow, empty);
        end
    endtask

    task automatic test_full_rw();
        logic [7:0] exp_b;
        for (int i = 0; i < 16; i++) write_byte(8'h20 + 8'(i));
        in_valid = 1'b1; in_data = 8'h77; rd_en = 1'b1;
        step();
        in_valid = 1'b0; rd_en = 1'b0;
        tests++;
        if (overflow !== 1'b0 || count !== 5'd16 || rd_valid !== 1'b1 || rd_data !== 8'h20) begin
            failed++;
            $display("FAIL full_rw: overflow=%b count=%0d rd_valid=%b rd_data=%h, want 0 16 1 20",
                     overflow, count, rd_valid, rd_data);
        end
        for (int i = 0; i < 16; i++) begin
            exp_b = (i < 15) ? 8'h21 + 8'(i) : 8'h77;
            read_once();
            tests++;
            if (rd_valid !== 1'b1 || rd_data !== exp_b) begin
                failed++;
                $display("FAIL full_rw_drain%0d: rd_valid=%b rd_data=%h, want 1 %h", i, rd_valid, rd_data, exp_b);
            end
        end
    endtask

    task automatic test_underflow();
        read_once();
        tests++;
        if (underflow !== 1'b1 || rd_valid !== 1'b0) begin
            failed++;
            $display("FAIL udf_set: underflow=%b rd_valid=%b, want 1 0", underflow, rd_valid);
        end
        clr_flags = 1'b1;
        step();
        tests++;
        if (underflow !== 1'b0) begin
            failed++;
            $display("FAIL udf_clear: underflow=%b, want 0", underflow);
        end
        rd_en = 1'b1;
        step();
        rd_en = 1'b0; clr_flags = 1'b0;
        tests++;
        if (underflow !== 1'b1) begin
            failed++;
            $display("FAIL udf_set_wins: underflow=%b, want 1", underflow);
        end
        in_valid = 1'b1; in_data = 8'h9C; rd_en = 1'b1; clr_flags = 1'b1;
        step();
        in_valid = 1'b0; rd_en = 1'b0; clr_flags = 1'b0;
        tests++;
        if (count !== 5'd1 || rd_valid !== 1'b0 || underflow !== 1'b1) begin
            failed++;
            $display("FAIL udf_no_bypass: count=%0d rd_valid=%b underflow=%b, want 1 0 1", count, rd_valid, underflow);
        end
        read_once();
        tests++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h9C || empty !== 1'b1) begin
            failed++;
            $display("FAIL udf_late_read: rd_valid=%b rd_data=%h empty=%b, want 1 9c 1", rd_valid, rd_data, empty);
        end
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
    endtask

    task automatic test_wrap_and_async_reset();
        for (int i = 0; i < 10; i++) write_byte(8'h30 + 8'(i));
        for (int i = 0; i < 10; i++) read_once();
        for (int i = 0; i < 10; i++) write_byte(8'h40 + 8'(i));
        for (int i = 0; i < 10; i++) begin
            read_once();
            tests++;
            if (rd_valid !== 1'b1 || rd_data !== 8'h40 + 8'(i)) begin
                failed++;
                $display("FAIL wrap_read%0d: rd_valid=%b rd_data=%h, want 1 %h", i, rd_valid, rd_data, 8'h40 + 8'(i));
            end
        end
        for (int i = 0; i < 3; i++) write_byte(8'hB0 + 8'(i));
        read_once();
        #1 resetn = 1'b0;
        #1;
        tests++;
        if (count !== 5'd0 || empty !== 1'b1 || rd_valid !== 1'b0) begin
            failed++;
            $display("FAIL async_reset: count=%0d empty=%b rd_valid=%b, want 0 1 0", count, empty, rd_valid);
        end
        #1 resetn = 1'b1;
        step();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 4; i++) write_byte(8'h60 + 8'(i));
        in_valid = 1'b1; in_data = 8'hEE; rd_en = 1'b1; flush = 1'b1;
        step();
        in_valid = 1'b0; rd_en = 1'b0; flush = 1'b0;
        tests++;
        if (count !== 5'd0 || empty !== 1'b1 || rd_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            failed++;
            $display("FAIL flush: count=%0d empty=%b rd_valid=%b ovf=%b udf=%b, want 0 1 0 0 0",
                     count, empty, rd_valid, overflow, underflow);
        end
        enable = 1'b0;
        write_byte(8'h11);
        enable = 1'b1;
        tests++;
        if (count !== 5'd0 || overflow !== 1'b0) begin
            failed++;
            $display("FAIL disabled_write: count=%0d overflow=%b, want 0 0", count, overflow);
        end
    endtask

    task automatic test_irq();
        apply_reset();
        for (int i = 0; i < 7; i++) write_byte(8'(i));
        step();
        tests++;
        if (irq !== 1'b0 || count !== 5'd7) begin
            failed++;
            $display("FAIL irq_below: irq=%b count=%0d, want 0 7", irq, count);
        end
        write_byte(8'h07);
        step();
        tests++;
        if (irq !== IRQ_ON || count !== 5'd8) begin
            failed++;
            $display("FAIL irq_level: irq=%b count=%0d, want %b 8", irq, count, IRQ_ON);
        end
        read_once();
        tests++;
        if (irq !== IRQ_ON || count !== 5'd7) begin
            failed++;
            $display("FAIL irq_hold: irq=%b count=%0d, want %b 7", irq, count, IRQ_ON);
        end
        step();
        tests++;
        if (irq !== 1'b0) begin
            failed++;
            $display("FAIL irq_release: irq=%b, want 0", irq);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_rw();
        test_underflow();
        test_wrap_and_async_reset();
        test_flush();
        test_irq();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
